hdr_radiance_accum: RTL

//  Per-pixel HDR merge stage wrapped around the exp LUT (exp_lut). For each pixel it takes N_EXP
//  8-bit log-radiance codes plus the raw exposure values Z, reads exp(code) from the LUT one

---
 rtl/hdr_pkg.sv | 29 ++
 rtl/hdr_hat_weight.sv | 11 +
 rtl/hdr_radiance_accum.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR radiance merge stage: default sizes,
// controller state encoding and the hat weighting function.
package hdr_pkg;

  localparam int N_EXP_DEF = 3;
  localparam int LUT_W_DEF = 32;
  localparam int W_W_DEF   = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  // Hat weight: ramps up over the dark half and down over the bright half,
  // so both clipped extremes (0 and 255) contribute nothing. For z >= 128,
  // 255 - z is simply the inverted low seven bits.
  function automatic logic [6:0] hat_weight(input logic [7:0] z);
    logic [6:0] w;
    if (z[7]) begin
      w = ~z[6:0];
    end else begin
      w = z[6:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/hdr_hat_weight.sv
// Combinational hat weighting of one raw exposure value.
module hdr_hat_weight
  import hdr_pkg::*;
(
  input  logic [7:0] z_i,
  output logic [6:0] w_o
);

  assign w_o = hat_weight(z_i);

endmodule

// File: rtl/hdr_radiance_accum.sv
// Per-pixel HDR merge: walks the exposures of one pixel through an external
// registered exp LUT, weights each returned radiance by the hat weight of its
// raw value, and accumulates numerator and denominator for the divider.
module hdr_radiance_accum
  import hdr_pkg::*;
#(
  parameter int N_EXP = N_EXP_DEF,
  parameter int LUT_W = LUT_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int NUM_W = LUT_W + W_W + $clog2(N_EXP),
  parameter int DEN_W = W_W + $clog2(N_EXP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [8*N_EXP-1:0]   pix_code,
  input  logic [8*N_EXP-1:0]   pix_z,
  output logic [7:0]           lut_addr,
  output logic                 lut_en,
  input  logic [LUT_W-1:0]     lut_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_W-1:0]     out_num,
  output logic [DEN_W-1:0]     out_den,
  output logic                 out_zero_w
);

  localparam int IDX_W  = $clog2(N_EXP);
  localparam int PROD_W = LUT_W + W_W;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [8*N_EXP-1:0]    codes_q;
  logic [8*N_EXP-1:0]    z_q;
  logic [W_W-1:0]        wdly_q;
  logic [NUM_W-1:0]      num_q;
  logic [DEN_W-1:0]      den_q;
  logic                  zero_q;
  logic [7:0]            addr_q;

  logic [7:0]            code_cur;
  logic [7:0]            z_cur;
  logic [6:0]            w_cur;
  logic                  last_idx;
  logic                  accept;
  logic                  acc_en;
  logic [PROD_W-1:0]     prod;
  logic [DEN_W-1:0]      den_sum;

  assign code_cur = codes_q[8*int'(idx_q) +: 8];
  assign z_cur    = z_q[8*int'(idx_q) +: 8];
  assign last_idx = (idx_q == IDX_W'(N_EXP - 1));
  assign accept   = (state_q == IDLE) && pix_valid;

  // LUT data lags its address by one cycle, so the product pairs it with the
  // weight captured alongside that address in the delay register.
  assign acc_en  = ((state_q == ISSUE) && (idx_q != '0)) || (state_q == DRAIN);
  assign prod    = PROD_W'(lut_data) * PROD_W'(wdly_q);
  assign den_sum = den_q + DEN_W'(wdly_q);

  hdr_hat_weight u_hat_weight (
    .z_i (z_cur),
    .w_o (w_cur)
  );

  // The address follows the exposure index while issuing and otherwise holds
  // whatever was last presented to the LUT.
  assign lut_addr   = (state_q == ISSUE) ? code_cur : addr_q;
  assign out_num    = num_q;
  assign out_den    = den_q;
  assign out_zero_w = zero_q;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/LUT-enable decode.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    lut_en    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) state_d = ISSUE;
      end
      ISSUE: begin
        lut_en = 1'b1;
        if (last_idx) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel capture, exposure index, weight delay and multiply-accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      codes_q <= '0;
      z_q     <= '0;
      wdly_q  <= '0;
      num_q   <= '0;
      den_q   <= '0;
      zero_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (accept) begin
        codes_q <= pix_code;
        z_q     <= pix_z;
        idx_q   <= '0;
        num_q   <= '0;
        den_q   <= '0;
        zero_q  <= 1'b0;
      end
      if (state_q == ISSUE) begin
        addr_q <= code_cur;
        wdly_q <= W_W'(w_cur);
        if (!last_idx) idx_q <= idx_q + 1'b1;
      end
      if (acc_en) begin
        num_q <= num_q + NUM_W'(prod);
        den_q <= den_sum;
      end
      if (state_q == DRAIN) begin
        zero_q <= (den_sum == '0);
      end
    end
  end

endmodule
